note_bitmap_writer: RTL and testbench

//  Index-to-bitmap writer: turns a stream of 7-bit note/voice index events into the

---
 rtl/note_bitmap_writer_if.sv | 22 ++
 rtl/note_bitmap_writer.sv | 84 ++++++++
 tb/tb_note_bitmap_writer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/note_bitmap_writer_if.sv
// rtl/note_bitmap_writer_if.sv - event input and release output streams of the bitmap writer
interface note_bitmap_writer_if #(
  parameter int IDX_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_set;
  logic             rel_valid;
  logic [IDX_W-1:0] rel_idx;
  logic             rel_ready;

  modport master (
    output in_valid, in_idx, in_set, rel_ready,
    input  in_ready, rel_valid, rel_idx
  );

  modport slave (
    input  in_valid, in_idx, in_set, rel_ready,
    output in_ready, rel_valid, rel_idx
  );
endinterface

// File: rtl/note_bitmap_writer.sv
// rtl/note_bitmap_writer.sv - index events to occupancy bitmap with popcount and ascending all-off sweep
module note_bitmap_writer #(
  parameter int WIDTH = 128,
  parameter int IDX_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  note_bitmap_writer_if.slave bus,
  input  logic               clr_all,
  output logic [WIDTH-1:0]   map,
  output logic [IDX_W:0]     count,
  output logic               busy,
  output logic               dup_err
);
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr;
  logic             accept, retire, ptr_bit, idx_bit;

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.rel_valid = 1'b0;
    bus.rel_idx   = ptr;
    busy          = 1'b0;
    accept        = 1'b0;
    retire        = 1'b0;
    ptr_bit       = map[ptr];
    idx_bit       = map[bus.in_idx];
    case (state)
      IDLE: begin
        // clr_all takes priority; a coincident event stays pending upstream
        bus.in_ready = ~clr_all;
        accept       = bus.in_valid & ~clr_all;
        if (clr_all) state_nx = SWEEP;
      end
      SWEEP: begin
        busy          = 1'b1;
        bus.rel_valid = ptr_bit;
        retire        = ~ptr_bit | bus.rel_ready;
        if (retire && ptr == LAST_PTR) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      map     <= '0;
      count   <= '0;
      ptr     <= '0;
      dup_err <= 1'b0;
    end else begin
      state   <= state_nx;
      dup_err <= 1'b0;
      if (accept) begin
        // setting a set bit or clearing a clear bit is rejected, which bounds count
        if (bus.in_set == idx_bit) begin
          dup_err <= 1'b1;
        end else if (bus.in_set) begin
          map[bus.in_idx] <= 1'b1;
          count           <= count + CNT_ONE;
        end else begin
          map[bus.in_idx] <= 1'b0;
          count           <= count - CNT_ONE;
        end
      end
      if (state == IDLE && clr_all) ptr <= '0;
      if (retire) begin
        ptr <= ptr + PTR_ONE;
        if (ptr_bit) begin
          map[ptr] <= 1'b0;
          count    <= count - CNT_ONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_note_bitmap_writer.sv
// tb/tb_note_bitmap_writer.sv - randomized self-checking bench against a set-of-notes reference model
module tb_note_bitmap_writer;
  localparam int WIDTH = 128;
  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_all = 1'b0;
  logic [WIDTH-1:0] map;
  logic [IDX_W:0]   count;
  logic             busy;
  logic             dup_err;

  note_bitmap_writer_if #(.IDX_W(IDX_W)) bus ();

  note_bitmap_writer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .clr_all (clr_all),
    .map     (map),
    .count   (count),
    .busy    (busy),
    .dup_err (dup_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit [WIDTH-1:0] ref_map = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_cnt();
    int s = 0;
    for (int i = 0; i < WIDTH; i++) s += int'(ref_map[i]);
    return s;
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_map"}, map, ref_map);
    check({tag, "_count"}, count, ref_cnt());
  endtask

  // called at posedge+1; returns at posedge+1 of the following cycle
  task automatic send(input int idx, input bit set);
    bit exp_dup;
    bus.in_valid = 1'b1;
    bus.in_idx   = idx[IDX_W-1:0];
    bus.in_set   = set;
    @(negedge clk);
    check("in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_dup      = set ? ref_map[idx] : !ref_map[idx];
    ref_map[idx] = set;
    check("dup_err", dup_err, exp_dup);
    check_state("send");
  endtask

  task automatic idle();
    @(posedge clk); #1;
    check("dup_idle", dup_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_map = '0;
  endtask

  // all-off sweep; stall_first = stall cycles on the first release, rand_stall adds random stalls
  task automatic sweep(input int stall_first, input bit rand_stall, input bit with_event, output int cyc);
    int exp_q[$];
    int stall_q[$];
    int exp_len, k, cnt, last_idx, exp_idx;
    bit stalled;
    exp_len = WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (ref_map[i]) begin
        int s;
        exp_q.push_back(i);
        s = (stall_q.size() == 0) ? stall_first : (rand_stall ? int'($urandom_range(0, 3)) : 0);
        stall_q.push_back(s);
        exp_len += s;
      end
    end
    clr_all = 1'b1;
    if (with_event) begin
      bus.in_valid = 1'b1;
      bus.in_set   = 1'b1;
      bus.in_idx   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) if (!ref_map[i]) bus.in_idx = 7'(i);
    end
    @(negedge clk);
    check("in_ready_clr", bus.in_ready, 0);
    @(posedge clk); #1;
    clr_all      = 1'b0;
    bus.in_valid = 1'b0;
    cyc = 0; k = 0; cnt = 0; stalled = 1'b0; last_idx = 0;
    while (busy && cyc < 5000) begin
      bus.rel_ready = (k < stall_q.size()) ? (cnt >= stall_q[k]) : 1'b1;
      clr_all       = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("in_ready_sweep", bus.in_ready, 0);
      if (bus.rel_valid) begin
        if (stalled) check("rel_idx_hold", bus.rel_idx, last_idx);
        if (bus.rel_ready) begin
          exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : 200;
          check("rel_order", bus.rel_idx, exp_idx);
          k++; cnt = 0; stalled = 1'b0;
        end else begin
          cnt++; stalled = 1'b1; last_idx = int'(bus.rel_idx);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    clr_all       = 1'b0;
    bus.rel_ready = 1'b0;
    ref_map       = '0;
    check("sweep_len", cyc, exp_len);
    check("rel_missing", exp_q.size(), 0);
    check("busy_end", busy, 0);
    check_state("sweep_end");
  endtask

  initial begin
    int cyc;
    bus.in_valid  = 1'b0;
    bus.in_idx    = '0;
    bus.in_set    = 1'b0;
    bus.rel_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    check("rst_map", map, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_rel_valid", bus.rel_valid, 0);
    check("rst_rel_idx", bus.rel_idx, 0);
    check("rst_dup", dup_err, 0);

    send(0, 1); send(5, 1); send(127, 1);
    check("t1_map", map, (128'd1 << 127) | (128'd1 << 5) | 128'd1);
    check("t1_count", count, 3);

    send(5, 1);
    idle();
    check("t2_count", count, 3);
    send(9, 0);
    idle();

    for (int i = 0; i < WIDTH; i++) send(i, 1);
    check("t3_full", map, {WIDTH{1'b1}});
    check("t3_count", count, 128);
    send(64, 0);
    check("t3_count127", count, 127);
    check("t3_bit64", map[64], 0);
    sweep(2, 1'b1, 1'b0, cyc);

    send(3, 1); send(70, 1);
    sweep(0, 1'b0, 1'b1, cyc);
    check("t4_len", cyc, 128);

    send(3, 1); send(70, 1);
    sweep(5, 1'b0, 1'b0, cyc);
    check("t5_len", cyc, 133);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) < 8)
          send((r[0] ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 127))), bit'($urandom_range(0, 2) != 0));
        else
          idle();
      end
      sweep(int'($urandom_range(0, 4)), 1'b1, bit'(r[1]), cyc);
    end

    for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 127)), 1'b1);
    clr_all = 1'b1;
    @(posedge clk); #1;
    clr_all       = 1'b0;
    bus.rel_ready = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("t6_busy_pre", busy, 1);
    do_reset();
    check("t6_map", map, 0);
    check("t6_count", count, 0);
    check("t6_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("t6_no_rel", bus.rel_valid, 0);
    end
    @(posedge clk); #1;
    bus.rel_ready = 1'b0;
    send(7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
